// File: rtl/imm_pkg.sv
// Shared immediate-format definitions for the decode path.
package imm_pkg;

  localparam int unsigned IMM_SRC_W = 3;

  typedef enum logic [IMM_SRC_W-1:0] {
    IMM_S = 3'b000,
    IMM_I = 3'b001,
    IMM_B = 3'b010,
    IMM_U = 3'b011,
    IMM_J = 3'b100
  } imm_src_e;

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// Combinational RV32I immediate extraction, sign-extended to XLEN.
module imm_extract
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]          instr_i,
  input  logic [IMM_SRC_W-1:0] imm_src_i,
  output logic [XLEN-1:0]      imm_o,
  output logic                 err_o
);

  logic [31:0] imm32;

  // Build the 32-bit immediate per format, then replicate its sign up to XLEN.
  always_comb begin
    imm32 = '0;
    err_o = 1'b0;
    case (imm_src_i)
      IMM_S:   imm32 = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      IMM_I:   imm32 = {{20{instr_i[31]}}, instr_i[31:20]};
      IMM_B:   imm32 = {{19{instr_i[31]}}, instr_i[31], instr_i[7],
                        instr_i[30:25], instr_i[11:8], 1'b0};
      IMM_U:   imm32 = {instr_i[31:12], 12'b0};
      IMM_J:   imm32 = {{11{instr_i[31]}}, instr_i[31], instr_i[19:12],
                        instr_i[20], instr_i[30:21], 1'b0};
      default: err_o = 1'b1;
    endcase
    imm_o       = {XLEN{imm32[31]}};
    imm_o[31:0] = imm32;
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic DEPTH-stage pipeline around imm_extract with flush and backpressure.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          instr,
  input  logic [IMM_SRC_W-1:0] ImmSrc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [XLEN-1:0]      ImmOp,
  output logic                 ImmErr
);

  logic [XLEN-1:0]  ext_imm;
  logic             ext_err;
  logic [DEPTH-1:0] valid_q, valid_d, adv;
  logic [XLEN-1:0]  imm_q [DEPTH];
  logic [XLEN-1:0]  imm_d [DEPTH];
  logic             err_q [DEPTH];
  logic             err_d [DEPTH];

  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr_i   (instr),
    .imm_src_i (ImmSrc),
    .imm_o     (ext_imm),
    .err_o     (ext_err)
  );

  // Ready chain from the output stage back to the input; a running OR keeps it acyclic.
  always_comb begin
    logic ready_up;
    ready_up = out_ready;
    adv      = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ready_up           = ready_up | ~valid_q[DEPTH-1-i];
      adv[DEPTH-1-i]     = ready_up;
    end
  end

  // Next-state: stages advance when ready; payload loads only with a valid entry.
  always_comb begin
    valid_d = valid_q;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      imm_d[k] = imm_q[k];
      err_d[k] = err_q[k];
    end
    if (adv[0]) begin
      valid_d[0] = in_valid;
      if (in_valid) begin
        imm_d[0] = ext_imm;
        err_d[0] = ext_err;
      end
    end
    for (int unsigned k = 1; k < DEPTH; k++) begin
      if (adv[k]) begin
        valid_d[k] = valid_q[k-1];
        if (valid_q[k-1]) begin
          imm_d[k] = imm_q[k-1];
          err_d[k] = err_q[k-1];
        end
      end
    end
    if (flush) valid_d = '0;
  end

  // Stage registers; reset clears valid and payload.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        imm_q[k] <= '0;
        err_q[k] <= 1'b0;
      end
    end else begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < DEPTH; k++) begin
        imm_q[k] <= imm_d[k];
        err_q[k] <= err_d[k];
      end
    end
  end

  // Outputs come from the last stage, zeroed while it holds no entry.
  always_comb begin
    in_ready  = adv[0];
    out_valid = valid_q[DEPTH-1];
    ImmOp     = out_valid ? imm_q[DEPTH-1] : '0;
    ImmErr    = out_valid & err_q[DEPTH-1];
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench: directed format checks on a DEPTH=1/XLEN=32 instance, queue-modelled
// stream checks on a DEPTH=3/XLEN=64 instance.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst;
  // DEPTH=1, XLEN=32 instance
  logic        in_valid1, flush1, out_ready1, in_ready1, out_valid1, err1;
  logic [31:0] instr1, op1;
  logic [2:0]  src1;
  // DEPTH=3, XLEN=64 instance
  logic        in_valid3, flush3, out_ready3, in_ready3, out_valid3, err3;
  logic [31:0] instr3;
  logic [63:0] op3;
  logic [2:0]  src3;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .flush(flush1), .in_valid(in_valid1), .in_ready(in_ready1),
    .instr(instr1), .ImmSrc(src1), .out_valid(out_valid1), .out_ready(out_ready1),
    .ImmOp(op1), .ImmErr(err1)
  );

  imm_gen_pipe #(.XLEN(64), .DEPTH(3)) dut3 (
    .clk(clk), .rst(rst), .flush(flush3), .in_valid(in_valid3), .in_ready(in_ready3),
    .instr(instr3), .ImmSrc(src3), .out_valid(out_valid3), .out_ready(out_ready3),
    .ImmOp(op3), .ImmErr(err3)
  );

  typedef struct {
    logic [63:0] imm;
    logic        err;
    int unsigned cyc;
  } ent_t;

  ent_t        q[$];
  int unsigned cyc = 0;
  bit          model_on = 1'b0;
  bit          last_acc;
  int          checks = 0;
  int          failures = 0;
  int          obs_pops, first_pop, last_pop;

  // Reference: immediate value from the field layout, using signed 64-bit arithmetic.
  function automatic logic [64:0] ref_imm(input logic [31:0] ins, input logic [2:0] src);
    longint s, v;
    s = longint'($signed(ins));
    case (src)
      3'd0: v = (s >>> 25) * 32 + longint'(ins[11:7]);
      3'd1: v = s >>> 20;
      3'd2: v = (s >>> 31) * 4096 + longint'(ins[7]) * 2048
                + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
      3'd3: v = (s >>> 12) * 4096;
      3'd4: v = (s >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
      default: return {1'b1, 64'd0};
    endcase
    return {1'b0, v};
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%b expected=%b", tag, got, exp);
    end
  endtask

  // One clock: check the DEPTH=3 instance against the queue model, then advance.
  task automatic tick();
    logic        exp_rdy, exp_vld, acc, con;
    logic [64:0] r;
    #1;
    exp_rdy = out_ready3 || (q.size() < 3);
    exp_vld = 1'b0;
    if (q.size() > 0) exp_vld = (cyc - q[0].cyc >= 3);
    if (model_on) begin
      chk1("m_in_ready", in_ready3, exp_rdy);
      chk1("m_out_valid", out_valid3, exp_vld);
      if (exp_vld) begin
        chk("m_imm", op3, q[0].imm);
        chk1("m_err", err3, q[0].err);
      end else begin
        chk("m_imm_idle", op3, 64'd0);
      end
    end
    if (out_valid3 && out_ready3) begin
      obs_pops++;
      if (obs_pops == 1) first_pop = int'(cyc);
      last_pop = int'(cyc);
    end
    acc      = in_valid3 && exp_rdy;
    con      = exp_vld && out_ready3;
    last_acc = acc && !flush3 && !rst;
    @(posedge clk);
    cyc++;
    if (rst || flush3) begin
      q.delete();
    end else begin
      if (con) void'(q.pop_front());
      if (acc) begin
        r = ref_imm(instr3, src3);
        q.push_back('{r[63:0], r[64], cyc - 1});
      end
    end
    #1;
  endtask

  logic [31:0] d_ins [7] = '{32'hFFF00093, 32'h00112423, 32'hFE000EE3, 32'h123450B7,
                             32'h0080006F, 32'h12345678, 32'hFFF00093};
  logic [2:0]  d_src [7] = '{3'd1, 3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
  logic [31:0] d_exp [7] = '{32'hFFFFFFFF, 32'h00000008, 32'hFFFFFFFC, 32'h12345000,
                             32'h00000008, 32'h00000000, 32'hFFFFFFFF};
  logic        d_err [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] bp_ins [6];
  logic [2:0]  bp_src [6];

  initial begin
    logic [64:0] r;
    int          sent;

    rst = 1'b1;
    in_valid1 = 1'b0; flush1 = 1'b0; out_ready1 = 1'b1; instr1 = '0; src1 = '0;
    in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1; instr3 = '0; src3 = '0;
    tick();
    tick();
    rst = 1'b0;
    model_on = 1'b1;

    // Reset state on both instances
    chk1("rst_valid1", out_valid1, 1'b0);
    chk("rst_imm1", 64'(op1), 64'd0);
    chk1("rst_err1", err1, 1'b0);
    chk1("rst_ready1", in_ready1, 1'b1);
    chk1("rst_valid3", out_valid3, 1'b0);
    chk1("rst_ready3", in_ready3, 1'b1);

    // Formats and illegal select, back-to-back, one cycle latency
    for (int i = 0; i < 7; i++) begin
      in_valid1 = 1'b1; instr1 = d_ins[i]; src1 = d_src[i];
      tick();
      chk1("fmt_valid", out_valid1, 1'b1);
      chk("fmt_imm", 64'(op1), 64'(d_exp[i]));
      chk1("fmt_err", err1, d_err[i]);
    end
    in_valid1 = 1'b0;
    tick();
    chk1("fmt_drain_valid", out_valid1, 1'b0);
    chk("fmt_drain_imm", 64'(op1), 64'd0);

    // XLEN=64 sign extension through DEPTH=3
    in_valid3 = 1'b1; instr3 = 32'hFFF00093; src3 = 3'd1;
    tick();
    in_valid3 = 1'b0;
    tick(); tick();
    chk1("w64_i_valid", out_valid3, 1'b1);
    chk("w64_i_imm", op3, 64'hFFFFFFFFFFFFFFFF);
    in_valid3 = 1'b1; instr3 = 32'h800000B7; src3 = 3'd3;
    tick();
    in_valid3 = 1'b0;
    tick(); tick();
    chk("w64_u_imm", op3, 64'hFFFFFFFF80000000);
    tick();

    // Backpressure: 6 entries, out_ready low for 5 cycles
    for (int i = 0; i < 6; i++) begin
      bp_ins[i] = $urandom;
      bp_src[i] = 3'($urandom_range(0, 4));
    end
    obs_pops = 0;
    sent = 0;
    for (int c = 0; c < 16; c++) begin
      out_ready3 = (c >= 5);
      in_valid3  = (sent < 6);
      if (sent < 6) begin
        instr3 = bp_ins[sent]; src3 = bp_src[sent];
      end
      if (c == 4) begin
        #1;
        r = ref_imm(bp_ins[0], bp_src[0]);
        chk1("bp_ready_low", in_ready3, 1'b0);
        chk1("bp_stall_valid", out_valid3, 1'b1);
        chk("bp_stall_hold", op3, r[63:0]);
      end
      tick();
      if (last_acc) sent++;
    end
    chk("bp_all_out", 64'(obs_pops), 64'd6);
    chk("bp_throughput", 64'(last_pop - first_pop), 64'd5);

    // Flush with three in flight plus a simultaneous input
    in_valid3 = 1'b1; out_ready3 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      instr3 = $urandom; src3 = 3'($urandom_range(0, 7));
      tick();
    end
    flush3 = 1'b1; instr3 = 32'hFFF00093; src3 = 3'd1;
    tick();
    flush3 = 1'b0; in_valid3 = 1'b0; out_ready3 = 1'b1;
    chk1("fl_valid", out_valid3, 1'b0);
    chk1("fl_ready", in_ready3, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    chk1("fl_never_out", out_valid3, 1'b0);

    // Reset mid-stream with a stalled, full pipeline
    in_valid3 = 1'b1; out_ready3 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      instr3 = $urandom; src3 = 3'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b1; flush3 = 1'b1;
    tick();
    rst = 1'b0; flush3 = 1'b0; in_valid3 = 1'b0;
    chk1("mrst_valid", out_valid3, 1'b0);
    chk("mrst_imm", op3, 64'd0);
    chk1("mrst_err", err3, 1'b0);
    chk1("mrst_ready", in_ready3, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 300; i++) begin
      in_valid3  = ($urandom_range(0, 3) != 0);
      out_ready3 = ($urandom_range(0, 2) != 0);
      flush3     = ($urandom_range(0, 24) == 0);
      instr3     = $urandom;
      src3       = 3'($urandom_range(0, 7));
      tick();
    end
    in_valid3 = 1'b0; flush3 = 1'b0; out_ready3 = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    chk1("end_empty", out_valid3, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
